// File: rtl/rsp_s2_dma_ahbic_pkg.sv
// rsp_s2_dma_ahbic_pkg: shared AHB encodings for the rsp_s2_dma interconnect.
// Contents: HTRANS, HBURST and HRESP encodings, and the packed address-phase
// control bundle that the input stage stores in its holding register.
package rsp_s2_dma_ahbic_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011
   } hburst_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   typedef struct packed {
      logic [1:0] trans;
      logic       write;
      logic [2:0] size;
      logic [2:0] burst;
      logic [3:0] prot;
      logic       lock;
   } ahb_ctrl_t;

endpackage

// File: rtl/rsp_s2_dma_ahbic_in_hold.sv
// rsp_s2_dma_ahbic_in_hold: address-phase holding register and output mux.
// Ports:
//   HCLK, HRESET       clock, asynchronous active-high reset
//   capture            load the live address phase into the register
//   hold_valid         register content is pending; selects it onto the outputs
//   conv               reissue a held SEQ beat as NONSEQ/INCR (burst restart)
//   HSELS/HADDRS/ctrl_s  live master address phase
//   HSELM/HADDRM/ctrl_m  address phase presented to the output stage
module rsp_s2_dma_ahbic_in_hold
   import rsp_s2_dma_ahbic_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              capture,
   input  logic              hold_valid,
   input  logic              conv,
   input  logic              HSELS,
   input  logic [ADDR_W-1:0] HADDRS,
   input  ahb_ctrl_t         ctrl_s,
   output logic              HSELM,
   output logic [ADDR_W-1:0] HADDRM,
   output ahb_ctrl_t         ctrl_m
);

   logic [ADDR_W-1:0] addr_q;
   ahb_ctrl_t         ctrl_q;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         addr_q <= '0;
         ctrl_q <= '0;
      end else if (capture) begin
         addr_q <= HADDRS;
         ctrl_q <= ctrl_s;
      end
   end

   assign HSELM  = hold_valid | HSELS;
   assign HADDRM = hold_valid ? addr_q : HADDRS;

   always_comb begin
      ctrl_m = hold_valid ? ctrl_q : ctrl_s;
      // A continuation beat after lost ownership must restart as an undefined-length burst
      if (conv && hold_valid && ctrl_q.trans == HTRANS_SEQ) begin
         ctrl_m.trans = HTRANS_NONSEQ;
         ctrl_m.burst = HBURST_INCR;
      end
   end

endmodule

// File: rtl/rsp_s2_dma_ahbic_in.sv
// rsp_s2_dma_ahbic_in: AHB interconnect input stage (request, pass-through/hold, response route).
// Ports:
//   HCLK, HRESET                  clock, asynchronous active-high reset
//   HSELS..HMASTLOCKS, HREADYS    master-side address phase and bus ready
//   HREADYOUTS, HRESPS            ready/response returned to the master
//   grant                         output stage currently routes this port
//   HREADYM, HRESPM               ready/response from the output stage/slave
//   req_port                      request to the output arbiter
//   HSELM..HMASTLOCKM             address phase presented to the output stage
// Build option: RSP_S2_DMA_AHBIC_IN_BURST_CONV_EN reissues a held SEQ beat as
// NONSEQ/INCR when grant was lost since this port's previous beat.
module rsp_s2_dma_ahbic_in
   import rsp_s2_dma_ahbic_pkg::*;
#(
   parameter int PORT_ID = 0,
   parameter int ADDR_W  = 32
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSELS,
   input  logic [ADDR_W-1:0] HADDRS,
   input  logic [1:0]        HTRANSS,
   input  logic              HWRITES,
   input  logic [2:0]        HSIZES,
   input  logic [2:0]        HBURSTS,
   input  logic [3:0]        HPROTS,
   input  logic              HMASTLOCKS,
   input  logic              HREADYS,
   output logic              HREADYOUTS,
   output logic              HRESPS,
   input  logic              grant,
   input  logic              HREADYM,
   input  logic              HRESPM,
   output logic              req_port,
   output logic              HSELM,
   output logic [ADDR_W-1:0] HADDRM,
   output logic [1:0]        HTRANSM,
   output logic              HWRITEM,
   output logic [2:0]        HSIZEM,
   output logic [2:0]        HBURSTM,
   output logic [3:0]        HPROTM,
   output logic              HMASTLOCKM
);

   // Port index lives in the arbiter's encoding; the stage itself is port-agnostic
   localparam int unused_port_id = PORT_ID;

   ahb_ctrl_t ctrl_s, ctrl_m;
   logic      hold_valid, data_phase, new_trans, accept, capture, issue, conv;

   assign ctrl_s = '{trans: HTRANSS, write: HWRITES, size: HSIZES, burst: HBURSTS,
                     prot: HPROTS, lock: HMASTLOCKS};

   assign new_trans = HSELS & HTRANSS[1] & HREADYS;
   assign accept    = grant & HREADYM;
   assign capture   = new_trans & ~accept;
   // hold_valid and new_trans are exclusive, so this covers pass-through and release
   assign issue     = accept & (hold_valid | new_trans);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         hold_valid <= 1'b0;
         data_phase <= 1'b0;
      end else begin
         hold_valid <= capture ? 1'b1 : (accept ? 1'b0 : hold_valid);
         data_phase <= issue ? 1'b1 : (HREADYM ? 1'b0 : data_phase);
      end
   end

`ifdef RSP_S2_DMA_AHBIC_IN_BURST_CONV_EN
   logic lost;
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) lost <= 1'b0;
      else        lost <= ~grant | (lost & ~issue);
   end
   assign conv = lost;
`else
   assign conv = 1'b0;
`endif

   rsp_s2_dma_ahbic_in_hold #(.ADDR_W(ADDR_W)) u_hold (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .capture    (capture),
      .hold_valid (hold_valid),
      .conv       (conv),
      .HSELS      (HSELS),
      .HADDRS     (HADDRS),
      .ctrl_s     (ctrl_s),
      .HSELM      (HSELM),
      .HADDRM     (HADDRM),
      .ctrl_m     (ctrl_m)
   );

   assign HTRANSM    = ctrl_m.trans;
   assign HWRITEM    = ctrl_m.write;
   assign HSIZEM     = ctrl_m.size;
   assign HBURSTM    = ctrl_m.burst;
   assign HPROTM     = ctrl_m.prot;
   assign HMASTLOCKM = ctrl_m.lock;

   assign req_port   = hold_valid | new_trans;
   assign HREADYOUTS = hold_valid ? 1'b0 : (data_phase ? HREADYM : 1'b1);
   assign HRESPS     = data_phase ? HRESPM : HRESP_OKAY;

endmodule

// File: tb/tb_rsp_s2_dma_ahbic_in.sv
// tb_rsp_s2_dma_ahbic_in: directed bench with a transaction-level reference model.
module tb_rsp_s2_dma_ahbic_in;

   localparam int AW = 32;
`ifdef RSP_S2_DMA_AHBIC_IN_BURST_CONV_EN
   localparam bit CONV = 1'b1;
`else
   localparam bit CONV = 1'b0;
`endif

   logic          HCLK = 1'b0, HRESET = 1'b1;
   logic          HSELS = 0, HWRITES = 0, HMASTLOCKS = 0, HREADYS;
   logic [AW-1:0] HADDRS = 0;
   logic [1:0]    HTRANSS = 0;
   logic [2:0]    HSIZES = 0, HBURSTS = 0;
   logic [3:0]    HPROTS = 0;
   logic          grant = 0, HREADYM = 1, HRESPM = 0;
   logic          HREADYOUTS, HRESPS, req_port, HSELM, HWRITEM, HMASTLOCKM;
   logic [AW-1:0] HADDRM;
   logic [1:0]    HTRANSM;
   logic [2:0]    HSIZEM, HBURSTM;
   logic [3:0]    HPROTM;

   int total = 0, bad = 0;

   always #5 HCLK = ~HCLK;

   rsp_s2_dma_ahbic_in #(.PORT_ID(0), .ADDR_W(AW)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
      .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
      .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
      .grant(grant), .HREADYM(HREADYM), .HRESPM(HRESPM), .req_port(req_port),
      .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
      .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM)
   );

   // Reference model: a pending-transfer slot, data-phase ownership, burst-break flag
   typedef struct {
      logic [AW-1:0] addr;
      logic [1:0]    trans;
      logic          write;
      logic [2:0]    size;
      logic [2:0]    burst;
      logic [3:0]    prot;
      logic          lock;
   } xfer_t;

   logic  m_pend = 0, m_own = 0, m_lost = 0;
   xfer_t m_x = '{default: 0};
   xfer_t live, e_x;
   logic  e_rdy, e_resp, e_req, e_sel, nt;

   always_comb begin
      live  = '{HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
      e_rdy = m_pend ? 1'b0 : (m_own ? HREADYM : 1'b1);
      nt    = HSELS && HTRANSS >= 2'd2 && HREADYS;
      e_resp = m_own && HRESPM;
      e_req = m_pend || nt;
      e_sel = m_pend || HSELS;
      e_x   = m_pend ? m_x : live;
      if (CONV && m_pend && m_lost && m_x.trans == 2'd3) begin
         e_x.trans = 2'd2;
         e_x.burst = 3'd1;
      end
   end

   // The master only presents a new address phase when the bus is ready
   assign HREADYS = e_rdy;

   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         m_pend <= 0; m_own <= 0; m_lost <= 0;
      end else begin
         automatic logic go = grant && HREADYM;
         automatic logic issued = go && (m_pend || nt);
         m_own  <= issued ? 1'b1 : (HREADYM ? 1'b0 : m_own);
         m_lost <= !grant ? 1'b1 : (issued ? 1'b0 : m_lost);
         if (nt && !go) begin
            m_pend <= 1; m_x <= live;
         end else if (go) m_pend <= 0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge HCLK) begin
      chk("HREADYOUTS", HREADYOUTS, e_rdy);
      chk("HRESPS", HRESPS, e_resp);
      chk("req_port", req_port, e_req);
      chk("HSELM", HSELM, e_sel);
      if (e_sel) begin
         chk("HADDRM", HADDRM, e_x.addr);
         chk("HTRANSM", HTRANSM, e_x.trans);
         chk("HWRITEM", HWRITEM, e_x.write);
         chk("HSIZEM", HSIZEM, e_x.size);
         chk("HBURSTM", HBURSTM, e_x.burst);
         chk("HPROTM", HPROTM, e_x.prot);
         chk("HMASTLOCKM", HMASTLOCKM, e_x.lock);
      end
   end

   task automatic step();
      @(posedge HCLK); #1;
   endtask

   task automatic drive(input logic [1:0] t, input logic w, input logic [AW-1:0] a, input logic [2:0] b);
      HSELS = (t != 2'd0); HTRANSS = t; HWRITES = w; HADDRS = a; HBURSTS = b;
   endtask

   initial begin
      #3;
      chk("rst_rdy", HREADYOUTS, 1'b1);
      chk("rst_resp", HRESPS, 1'b0);
      chk("rst_req", req_port, 1'b0);
      chk("rst_sel", HSELM, 1'b0);
      chk("rst_trans", HTRANSM, 2'd0);
      step(); step();
      HRESET = 0;
      step();
      // pass-through write
      grant = 1; HREADYM = 1; HSIZES = 3'd2; HPROTS = 4'h3;
      drive(2'd2, 1, 32'h1000, 3'd0); #1;
      chk("pt_trans", HTRANSM, 2'd2);
      chk("pt_addr", HADDRM, 32'h1000);
      chk("pt_rdy", HREADYOUTS, 1'b1);
      step(); drive(2'd0, 0, 0, 0); step();
      // buffered read, grant three cycles later
      grant = 0; drive(2'd2, 0, 32'h2000, 3'd0); #1;
      chk("buf_rdy0", HREADYOUTS, 1'b1);
      chk("buf_req0", req_port, 1'b1);
      step(); HADDRS = 32'hdead; #1;
      chk("buf_rdy1", HREADYOUTS, 1'b0);
      chk("buf_addr1", HADDRM, 32'h2000);
      step(); #1;
      chk("buf_rdy2", HREADYOUTS, 1'b0);
      chk("buf_req2", req_port, 1'b1);
      step(); grant = 1; #1;
      chk("buf_rdy3", HREADYOUTS, 1'b0);
      chk("rel_addr", HADDRM, 32'h2000);
      chk("rel_trans", HTRANSM, 2'd2);
      step(); drive(2'd0, 0, 0, 0); #1;
      chk("buf_rdy4", HREADYOUTS, 1'b1);
      step();
      // two slave wait states
      drive(2'd2, 1, 32'h1100, 3'd0); step();
      drive(2'd0, 0, 0, 0); HREADYM = 0; #1; chk("ws_rdy0", HREADYOUTS, 1'b0);
      step(); #1; chk("ws_rdy1", HREADYOUTS, 1'b0);
      step(); HREADYM = 1; #1; chk("ws_rdy2", HREADYOUTS, 1'b1);
      step();
      // ERROR response
      drive(2'd2, 0, 32'h1200, 3'd0); step();
      drive(2'd0, 0, 0, 0); HREADYM = 0; HRESPM = 1; #1;
      chk("err_resp0", HRESPS, 1'b1);
      chk("err_rdy0", HREADYOUTS, 1'b0);
      step(); HREADYM = 1; #1;
      chk("err_resp1", HRESPS, 1'b1);
      chk("err_rdy1", HREADYOUTS, 1'b1);
      step(); HRESPM = 0; step();
      // INCR4 burst interrupted by grant loss
      HMASTLOCKS = 1; drive(2'd2, 1, 32'h3000, 3'd3); step();
      grant = 0; drive(2'd3, 1, 32'h3004, 3'd3); step(); step();
      grant = 1; #1;
      chk("brst_addr", HADDRM, 32'h3004);
      chk("brst_lock", HMASTLOCKM, 1'b1);
      chk("brst_trans", HTRANSM, CONV ? 2'd2 : 2'd3);
      chk("brst_burst", HBURSTM, CONV ? 3'd1 : 3'd3);
      step(); drive(2'd0, 0, 0, 0); HMASTLOCKS = 0; step();
      // mixed traffic with alternating grant
      for (int i = 0; i < 8; i++) begin
         grant = i[0]; HSIZES = 3'(i); HPROTS = 4'(i * 3); HMASTLOCKS = i[1];
         drive(2'd2, i[2], 32'h5000 + 32'(i * 4), 3'd0); step();
      end
      drive(2'd0, 0, 0, 0); grant = 1; step(); step();
      // reset while a transfer is held
      grant = 0; drive(2'd2, 1, 32'h4000, 3'd0); step();
      #2; HRESET = 1; drive(2'd0, 0, 0, 0); #1;
      chk("mrst_rdy", HREADYOUTS, 1'b1);
      chk("mrst_req", req_port, 1'b0);
      step(); HRESET = 0; grant = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("post_trans", HTRANSM, 2'd0);
         chk("post_req", req_port, 1'b0);
         chk("post_sel", HSELM, 1'b0);
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rsp_s2_dma_ahbic_in.md
# rsp_s2_dma_ahbic_in

Input stage of the rsp_s2_dma AHB interconnect: it sits between one AHB master port and the matrix output stages, which are driven by the fixed-priority output arbiter. It raises the arbiter request, passes address phases straight through when the port already owns the slave path, and buffers an address phase in a holding register (inserting wait states) when it does not. It also routes the slave data-phase response back to the master.

## Interface
- PORT_ID, 0: index of this input port; matches the arbiter's addr_in_port encoding.
- ADDR_W, 32: address width.
- HCLK  in  1  AHB system clock
- HRESET  in  1  asynchronous active-high reset
- HSELS  in  1  master-side select
- HADDRS  in  ADDR_W  master address
- HTRANSS  in  2  master transfer type
- HWRITES  in  1  master write
- HSIZES  in  3  master size
- HBURSTS  in  3  master burst
- HPROTS  in  4  master protection
- HMASTLOCKS  in  1  master lock
- HREADYS  in  1  master-side bus ready (address phase accepted)
- HREADYOUTS  out  1  ready returned to master
- HRESPS  out  1  response returned to master
- grant  in  1  output stage currently routes this port (addr_in_port==PORT_ID and no_port==0)
- HREADYM  in  1  ready from output stage/slave
- HRESPM  in  1  response from slave
- req_port  out  1  request to output arbiter
- HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM  out  widths as master side  address phase presented to output stage

## Operation
- new_trans = HSELS & HTRANSS[1] & HREADYS (NONSEQ or SEQ only; IDLE/BUSY never stored).
- State flags: hold_valid (held address phase pending), data_phase (this port owns current slave data phase).
- req_port = hold_valid | new_trans.
- Output mux: hold_valid ? holding register : live master signals; HSELM = hold_valid | HSELS.
- Pass-through: new_trans & grant & HREADYM & ~hold_valid -> accepted by slave same cycle, data_phase <= 1, nothing stored.
- Capture: new_trans & ~(grant & HREADYM) -> holding register loads all address-phase fields, hold_valid <= 1.
- Release: hold_valid & grant & HREADYM -> hold_valid <= 0, data_phase <= 1.
- data_phase clears on HREADYM when no new transfer of this port is accepted that cycle.
- HREADYOUTS: 0 while hold_valid; else HREADYM when data_phase; else 1.
- HRESPS: HRESPM when data_phase; else OKAY (0).
- hold_valid and new_trans cannot coexist: the master stalls while HREADYOUTS=0, so HREADYS=0.
- Lock: HMASTLOCKS captured with the transfer; held lock asserted on HMASTLOCKM until release.

## Timing
- Reset (asynchronous, HRESET high): hold_valid=0, data_phase=0, holding register 0; HREADYOUTS=1, HRESPS=0, req_port=0, HSELM=0, HTRANSM=IDLE.
- Pass-through latency 0 cycles; buffered latency = cycles until grant&HREADYM, minimum 1 wait state.
- ERROR response (2 cycles): HRESPS follows HRESPM both cycles; HREADYOUTS=0 then 1.
- Release and capture never occur in the same cycle.
- Reset mid-hold drops the held transfer; no request is issued after reset.

## Configuration
- RSP_S2_DMA_AHBIC_IN_BURST_CONV_EN defined: a held SEQ transfer is issued as NONSEQ with HBURSTM forced to INCR when grant was lost since the previous beat of this port, so an interrupted burst is valid at the slave.
- Not defined: held fields are issued unmodified.

## Structure
- Shared package rsp_s2_dma_ahbic_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HBURST INCR, HRESP OKAY/ERROR constants.
- One natural sub-module: rsp_s2_dma_ahbic_in_hold, the holding register plus its output mux.

## Test plan
- grant=1, HREADYM=1, NONSEQ write to 0x1000 -> HTRANSM=NONSEQ and HADDRM=0x1000 in the same cycle, HREADYOUTS=1, no hold.
- grant=0, NONSEQ read to 0x2000, grant=1 three cycles later -> req_port=1 throughout, HREADYOUTS=0 for 3 cycles, HADDRM=0x2000 on release.
- Pass-through transfer, slave inserts 2 wait states (HREADYM=0,0,1) -> HREADYOUTS=0,0,1.
- Slave ERROR response -> HRESPS=1 for 2 cycles, HREADYOUTS=0 then 1.
- Macro defined, INCR4 SEQ beat held after a grant loss -> HTRANSM=NONSEQ, HBURSTM=INCR; macro undefined -> HTRANSM=SEQ, HBURSTM=INCR4.
- Assert HRESET while hold_valid=1 -> HREADYOUTS=1, req_port=0 immediately; no transfer is issued after reset is released.
